// File: rtl/add_serial_arb_pkg.sv
// Shared types and constants for the add_serial arbiter: FSM state encoding,
// adder width and the default adder latency.
package add_serial_pkg;
  localparam int ADD_SERIAL_W   = 8;
  localparam int ADD_SERIAL_LAT = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/add_serial_arb_rr_pick.sv
// Combinational round-robin selector: returns the first asserted request
// at or after ptr+1, searching upward with wrap.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  always_comb begin
    any = 1'b0;
    idx = '0;
    dbl = {req, req};
    // rot[k] is the request of requester (ptr+1+k) mod N
    rot = N'(dbl >> ((int'(ptr) + 1) % N));
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        idx = IDW'((int'(ptr) + 1 + k) % N);
      end
    end
  end
endmodule

// File: rtl/add_serial_arb.sv
// Round-robin arbiter/sequencer sharing one bit-serial adder among N requesters.
// Define ADD_SERIAL_ARB_STATS_EN to add the ops_done / max_wait statistics ports.
module add_serial_arb
  import add_serial_pkg::*;
#(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int ADD_LAT = ADD_SERIAL_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              req,
  input  logic [ADD_SERIAL_W*N-1:0] req_a,
  input  logic [ADD_SERIAL_W*N-1:0] req_b,
  output logic [N-1:0]              gnt,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic [ADD_SERIAL_W-1:0]   rsp_sum,
  output logic                      busy,
  output logic                      add_en,
  output logic [ADD_SERIAL_W-1:0]   add_a,
  output logic [ADD_SERIAL_W-1:0]   add_b,
  input  logic [ADD_SERIAL_W-1:0]   add_out
`ifdef ADD_SERIAL_ARB_STATS_EN
  ,
  output logic [15:0]               ops_done,
  output logic [7:0]                max_wait
`endif
);
  localparam int W  = ADD_SERIAL_W;
  localparam int CW = $clog2(ADD_LAT + 1);

  state_t         state_reg, state_next;
  logic [IDW-1:0] cur_id_reg, cur_id_next;
  logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [N-1:0]   gnt_reg, gnt_next;
  logic           add_en_reg, add_en_next;
  logic [W-1:0]   add_a_reg, add_a_next;
  logic [W-1:0]   add_b_reg, add_b_next;
  logic           rsp_valid_reg, rsp_valid_next;
  logic [IDW-1:0] rsp_id_reg, rsp_id_next;
  logic [W-1:0]   rsp_sum_reg, rsp_sum_next;
  logic           busy_reg, busy_next;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic [W-1:0]   sel_a, sel_b;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req (req),
    .ptr (rr_ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == pick_idx) begin
        sel_a = req_a[W*i +: W];
        sel_b = req_b[W*i +: W];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    cur_id_next    = cur_id_reg;
    rr_ptr_next    = rr_ptr_reg;
    cnt_next       = cnt_reg;
    gnt_next       = '0;
    add_en_next    = 1'b0;
    add_a_next     = add_a_reg;
    add_b_next     = add_b_reg;
    rsp_valid_next = 1'b0;
    rsp_id_next    = rsp_id_reg;
    rsp_sum_next   = rsp_sum_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          // gnt/add_en are registered, so they are launched here to appear in ISSUE
          add_a_next  = sel_a;
          add_b_next  = sel_b;
          cur_id_next = pick_idx;
          add_en_next = 1'b1;
          for (int i = 0; i < N; i++) gnt_next[i] = (IDW'(i) == pick_idx);
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        rr_ptr_next = cur_id_reg;
        cnt_next    = CW'(1);
        state_next  = RUN;
      end
      RUN: begin
        if (cnt_reg == CW'(ADD_LAT)) begin
          rsp_sum_next   = add_out;
          rsp_id_next    = cur_id_reg;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cur_id_reg    <= '0;
      rr_ptr_reg    <= IDW'(N - 1);
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      add_en_reg    <= 1'b0;
      add_a_reg     <= '0;
      add_b_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_sum_reg   <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_id_reg    <= cur_id_next;
      rr_ptr_reg    <= rr_ptr_next;
      cnt_reg       <= cnt_next;
      gnt_reg       <= gnt_next;
      add_en_reg    <= add_en_next;
      add_a_reg     <= add_a_next;
      add_b_reg     <= add_b_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_sum_reg   <= rsp_sum_next;
      busy_reg      <= busy_next;
    end
  end

  assign gnt       = gnt_reg;
  assign add_en    = add_en_reg;
  assign add_a     = add_a_reg;
  assign add_b     = add_b_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign busy      = busy_reg;

`ifdef ADD_SERIAL_ARB_STATS_EN
  logic [15:0] ops_done_reg;
  logic [7:0]  max_wait_reg;
  logic [7:0]  wait_reg [N];

  // Per-requester wait counts only cycles the arbiter could actually see (IDLE)
  for (genvar gi = 0; gi < N; gi++) begin : g_wait
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wait_reg[gi] <= '0;
      end else if (gnt_reg[gi] || !req[gi]) begin
        wait_reg[gi] <= '0;
      end else if (state_reg == IDLE && wait_reg[gi] != 8'hFF) begin
        wait_reg[gi] <= wait_reg[gi] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done_reg <= '0;
      max_wait_reg <= '0;
    end else begin
      if (state_reg == RESP && ops_done_reg != 16'hFFFF)
        ops_done_reg <= ops_done_reg + 16'd1;
      if (state_reg == ISSUE && wait_reg[cur_id_reg] > max_wait_reg)
        max_wait_reg <= wait_reg[cur_id_reg];
    end
  end

  assign ops_done = ops_done_reg;
  assign max_wait = max_wait_reg;
`endif
endmodule

// File: tb/tb_add_serial_arb.sv
// Scoreboard bench for add_serial_arb: a transaction-level arbitration model
// predicts grants and responses, a separate monitor checks every response.
module tb_add_serial_arb;
  import add_serial_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = ADD_SERIAL_LAT;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [7:0]     rsp_sum;
  logic           busy;
  logic           add_en;
  logic [7:0]     add_a;
  logic [7:0]     add_b;
  logic [7:0]     add_out;
`ifdef ADD_SERIAL_ARB_STATS_EN
  logic [15:0]    ops_done;
  logic [7:0]     max_wait;
`endif

  add_serial_arb #(.N(N), .IDW(IDW), .ADD_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_out   (add_out)
`ifdef ADD_SERIAL_ARB_STATS_EN
    ,
    .ops_done  (ops_done),
    .max_wait  (max_wait)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: output is garbage until LAT cycles after the enable edge
  logic [7:0] asum;
  int         acnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_out <= '0;
      asum    <= '0;
      acnt    <= 0;
    end else if (add_en) begin
      asum    <= add_a + add_b;
      acnt    <= LAT - 1;
      add_out <= 8'($urandom);
    end else if (acnt != 0) begin
      acnt <= acnt - 1;
      if (acnt == 1) add_out <= asum;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int id;
    int sum;
    int due;
  } exp_t;

  exp_t         exp_q[$];
  int           busy_until = 0;
  int           last_id    = N - 1;
  logic [N-1:0] exp_gnt    = '0;
  int           last_sum   = -1;
  int           last_rid   = -1;
  int           nrsp       = 0;

  // Predictor: one operation at a time, round-robin from the last granted id
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctrl", int'({gnt, rsp_valid, busy, add_en, rsp_id}), 0);
      chk("rst_data", int'({rsp_sum, add_a, add_b}), 0);
`ifdef ADD_SERIAL_ARB_STATS_EN
      chk("rst_ops_done", ops_done, 0);
`endif
      exp_q.delete();
      busy_until = 0;
      last_id    = N - 1;
      exp_gnt    = '0;
    end else begin
      if (gnt != '0 || exp_gnt != '0) chk("gnt", gnt, exp_gnt);
      chk("add_en", add_en, int'(exp_gnt != '0));
      chk("busy", busy, int'(cyc < busy_until));
      exp_gnt = '0;
      if (cyc >= busy_until && req != '0) begin
        int  j;
        bit  found;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req[(last_id + k) % N]) begin
            found = 1'b1;
            j     = (last_id + k) % N;
          end
        end
        exp_gnt    = '0;
        exp_gnt[j] = 1'b1;
        last_id    = j;
        exp_q.push_back('{j, (int'(req_a[8*j +: 8]) + int'(req_b[8*j +: 8])) % 256, cyc + LAT + 2});
        busy_until = cyc + LAT + 3;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a response
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      nrsp = 0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_sum", rsp_sum, e.sum);
        chk("rsp_latency", cyc, e.due);
        nrsp++;
        last_sum = rsp_sum;
        last_rid = rsp_id;
        $display("rsp cyc=%0d id=%0d sum=%02h", cyc, rsp_id, rsp_sum);
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
      chk("rsp_missing", cyc, exp_q[0].due);
      void'(exp_q.pop_front());
    end
  end

  logic [N-1:0] auto_re = '0;
  int           g_id[$];
  int           g_cyc[$];

  task automatic raise(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req[i]          = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        req[i] = 1'b0;
        g_id.push_back(i);
        g_cyc.push_back(cyc);
      end
      if (auto_re[i] && rsp_valid && rsp_id == IDW'(i))
        raise(i, 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while ((busy || req != '0 || gnt != '0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("idle_timeout", n, 0);
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    while (g_id.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("gnt_timeout", n, 0);
  endtask

  initial begin
    int fair_exp[6];
    fair_exp = '{0, 1, 2, 3, 0, 1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // single add and overflow wrap
    raise(0, 8'h35, 8'h4A);
    wait_idle();
    chk("single_sum", last_sum, 'h7F);
    chk("single_id", last_rid, 0);
    raise(2, 8'hFF, 8'h01);
    wait_idle();
    chk("ovf_sum", last_sum, 0);
    chk("ovf_id", last_rid, 2);
    raise(2, 8'h80, 8'h80);
    wait_idle();
    chk("ovf2_sum", last_sum, 0);

    // wrap priority after a grant to 3
    raise(3, 8'h11, 8'h22);
    wait_idle();
    g_id.delete();
    g_cyc.delete();
    raise(0, 8'h01, 8'h02);
    raise(2, 8'h03, 8'h04);
    wait_idle();
    chk("wrap_count", g_id.size(), 2);
    if (g_id.size() == 2) begin
      chk("wrap_first", g_id[0], 0);
      chk("wrap_second", g_id[1], 2);
    end

    // fairness with continuous re-requests, starting after a grant to 3
    raise(3, 8'h05, 8'h06);
    wait_idle();
    g_id.delete();
    g_cyc.delete();
    auto_re = '1;
    for (int i = 0; i < N; i++) raise(i, 8'($urandom), 8'($urandom));
    for (int n = 0; n < 200 && g_id.size() < 6; n++) tick();
    auto_re = '0;
    wait_idle();
    chk("fair_count_min", int'(g_id.size() >= 6), 1);
    for (int k = 0; k < 6 && k < g_id.size(); k++) chk("fair_order", g_id[k], fair_exp[k]);
    for (int k = 1; k < 6 && k < g_cyc.size(); k++) chk("fair_spacing", g_cyc[k] - g_cyc[k-1], LAT + 3);

    // withdraw: requester 1 drops its request while 0 is running
    g_id.delete();
    raise(0, 8'h10, 8'h20);
    wait_gnt();
    raise(1, 8'h30, 8'h40);
    repeat (3) tick();
    req[1] = 1'b0;
    wait_idle();
    chk("withdraw_grants", g_id.size(), 1);

    // asynchronous reset in the middle of RUN
    g_id.delete();
    raise(0, 8'h77, 8'h01);
    wait_gnt();
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", int'({gnt, rsp_valid, busy, add_en}), 0);
    chk("async_rst_sum", int'({rsp_sum, add_a, add_b}), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    chk("post_rst_no_rsp", nrsp, 0);
    raise(0, 8'h12, 8'h34);
    wait_idle();
    chk("post_rst_sum", last_sum, 'h46);
    chk("post_rst_id", last_rid, 0);

    // randomized traffic with occasional withdrawals
    repeat (400) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(7) == 0) raise(i, 8'($urandom), 8'($urandom));
        else if (req[i] && $urandom_range(39) == 0) req[i] = 1'b0;
      end
    end
    wait_idle();
    repeat (2) tick();
    chk("queue_empty", exp_q.size(), 0);
`ifdef ADD_SERIAL_ARB_STATS_EN
    chk("ops_done", ops_done, nrsp);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/add_serial_arb.md
Name: add_serial_arb

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit bit-serial adder (add_serial) among N requesters.
- Accepts operand pairs from requesters and issues each accepted pair to the adder with a single-cycle enable.
- Counts the adder's fixed latency, captures the sum and returns it to the owning requester with that requester's ID.
- Sits between client blocks and the single add_serial instance; it is the only block that drives add_serial inputs.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2**IDW >= N.
- ADD_LAT, 9, cycles from the add_en cycle to a valid add_out; 9 for 8-bit add_serial (1 load + 8 shift).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request; held high with operands stable until gnt.
- req_a  in  8*N  operand A, packed; requester i uses bits [8i+7:8i].
- req_b  in  8*N  operand B, packed.
- gnt  out  N  one-hot, single-cycle pulse; marks the requester accepted.
- rsp_valid  out  1  single-cycle pulse; rsp_sum and rsp_id are valid.
- rsp_id  out  IDW  requester that owns the response.
- rsp_sum  out  8  (A+B) mod 256.
- busy  out  1  high in any state other than IDLE.
- add_en  out  1  to add_serial en.
- add_a  out  8  to add_serial a.
- add_b  out  8  to add_serial b.
- add_out  in  8  from add_serial out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rr_ptr=N-1, so requester 0 has highest priority first.
  - gnt=0, rsp_valid=0, rsp_id=0, rsp_sum=0, add_en=0, add_a=0, add_b=0, cnt=0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RUN, RESP.
- IDLE:
  - If any req bit is high, select the first requester at or after rr_ptr+1, searching upward with wrap.
  - Latch that requester's operands into add_a/add_b and its index into cur_id; go to ISSUE.
  - If no req bit is high, stay in IDLE.
- ISSUE (1 cycle):
  - add_en=1, gnt[cur_id]=1; rr_ptr<=cur_id; cnt<=1; go to RUN.
- RUN:
  - add_en=0; cnt increments each cycle.
  - When cnt==ADD_LAT: rsp_sum<=add_out, rsp_id<=cur_id; go to RESP.
- RESP (1 cycle):
  - rsp_valid=1; go to IDLE.
- Latency: req seen in IDLE -> gnt 1 cycle later -> rsp_valid ADD_LAT+1 cycles after gnt.
- Throughput: one operation per ADD_LAT+3 cycles.
- add_en low for at least ADD_LAT+2 cycles between issues, which lets add_serial return to its IDLE state.
- add_a/add_b are held stable from ISSUE through RESP.
- Boundary conditions:
  - req bits that change outside IDLE are ignored.
  - A requester that drops req before gnt is not served; no response is generated.
  - Only one operation is in flight at a time.
  - Requester i's next request is not granted in the cycle of its own RESP, because arbitration happens only in IDLE.
  - Sum overflow wraps mod 256; no carry-out is reported.
  - cnt is $clog2(ADD_LAT+1) bits wide and never wraps.
  - Reset mid-operation aborts it: no rsp_valid and no gnt after reset release. The adder must be reset by the same reset domain.
  - rr_ptr advances only on grant, so a lone requester is re-granted repeatedly.

Optional Feature:
- Macro: ADD_SERIAL_ARB_STATS_EN.
- Defined:
  - Adds output port ops_done (16 bits): count of RESP cycles, saturating at 16'hFFFF, reset to 0.
  - Adds output port max_wait (8 bits): the largest number of IDLE-visible cycles any requester held req before gnt, saturating at 8'hFF, reset to 0.
- Undefined: neither port exists and no counter logic is synthesised; all other behaviour is identical.

Decomposition:
- Package add_serial_pkg:
  - state enum (IDLE, ISSUE, RUN, RESP, 2 bits).
  - ADD_SERIAL_W=8.
  - default latency constant ADD_SERIAL_LAT=9.
- Sub-module rr_pick:
  - combinational round-robin selector.
  - inputs: req[N], ptr[IDW]; outputs: any, idx[IDW].
  - instantiated once.

Test Plan:
- Single add: req[0] with A=0x35, B=0x4A against an add_serial model -> gnt[0] pulse; rsp_valid 10 cycles later; rsp_sum=0x7F, rsp_id=0.
- Overflow: req[2] with A=0xFF, B=0x01 -> rsp_sum=0x00, rsp_id=2. A=0x80, B=0x80 -> 0x00.
- Fairness: req=4'b1111 held continuously, each requester reasserting after its response -> grant order 0,1,2,3,0,1; each gnt spaced 12 cycles apart; every sum correct.
- Wrap priority: after a grant to 3, req=4'b0101 -> next grant 0, then 2.
- Withdraw: req[1] dropped while the FSM is in RUN for requester 0 -> no grant and no response for requester 1; busy falls after RESP.
- Reset mid-RUN: rst_n low for 2 cycles at cnt=4 -> all outputs 0 immediately; no rsp_valid afterwards; next req[0] is served normally. With STATS_EN: ops_done=0 after reset.
